// File: rtl/lcd_controller.sv
`default_nettype none
// ============================================================================
// Module   : lcd_controller
// Purpose  : Write-only character LCD controller behind a custom-instruction
//            port: byte writes, timed E strobe, init sequence, one-deep queue.
// Revision : 1.0  initial release
// ============================================================================
module lcd_controller #(
    parameter int EN_PULSE_CYC     = 25,
    parameter int CMD_WAIT_CYC     = 2500,
    parameter int CLEAR_WAIT_CYC   = 82000,
    parameter int POWERUP_WAIT_CYC = 750000,
    parameter bit INIT_ON_RESET    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        lcd_enable,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
);

    localparam int C_MAX_A    = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
    localparam int C_MAX_B    = (CLEAR_WAIT_CYC > POWERUP_WAIT_CYC) ? CLEAR_WAIT_CYC : POWERUP_WAIT_CYC;
    localparam int C_MAX_WAIT = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    localparam int C_CNT_W    = ($clog2(C_MAX_WAIT + 1) > 20) ? $clog2(C_MAX_WAIT + 1) : 20;

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_POWERUP = 3'd1;
    localparam logic [2:0] C_SETUP   = 3'd2;
    localparam logic [2:0] C_PULSE   = 3'd3;
    localparam logic [2:0] C_WAIT    = 3'd4;
    localparam logic [2:0] C_NEXT    = 3'd5;
    localparam logic [2:0] C_DONE    = 3'd6;

    logic [2:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_rs;
    logic [7:0]         r_byte;
    logic [31:0]        r_result;
    logic               r_init_flag;
    logic               r_init_run;
    logic               r_init_auto;
    logic [1:0]         r_init_idx;
    logic               r_pend_valid;
    logic [7:0]         r_pend_byte;
    logic               r_pend_rs;
    logic               r_pend_init;

    logic               w_last_init;
    logic               w_launch_pt;
    logic               w_req_valid;
    logic               w_req_init;
    logic               w_req_rs;
    logic [7:0]         w_req_byte;
    logic [C_CNT_W-1:0] w_wait_cyc;
    logic               w_unused;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0F;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    assign w_last_init = r_init_run && (r_init_idx == 2'd3);
    // Points where a new operation may begin: idle, done, or the tail of an automatic init
    assign w_launch_pt = (r_state == C_IDLE) || (r_state == C_DONE) ||
                         ((r_state == C_NEXT) && w_last_init && r_init_auto);
    assign w_req_valid = r_pend_valid || start;
    assign w_req_init  = r_pend_valid ? r_pend_init : datab[1];
    assign w_req_rs    = r_pend_valid ? r_pend_rs   : datab[0];
    assign w_req_byte  = r_pend_valid ? r_pend_byte : dataa[7:0];
    assign w_wait_cyc  = (!r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02))) ?
                         C_CNT_W'(CLEAR_WAIT_CYC) : C_CNT_W'(CMD_WAIT_CYC);
    assign w_unused    = ^{dataa[31:8], datab[31:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= INIT_ON_RESET ? C_POWERUP : C_IDLE;
            r_cnt        <= INIT_ON_RESET ? C_CNT_W'(POWERUP_WAIT_CYC - 1) : '0;
            r_rs         <= 1'b0;
            r_byte       <= 8'h00;
            r_result     <= 32'h0;
            r_init_flag  <= 1'b0;
            r_init_run   <= INIT_ON_RESET;
            r_init_auto  <= INIT_ON_RESET;
            r_init_idx   <= 2'd0;
            r_pend_valid <= 1'b0;
            r_pend_byte  <= 8'h00;
            r_pend_rs    <= 1'b0;
            r_pend_init  <= 1'b0;
        end else if (clk_en) begin
            if (w_launch_pt) begin
                r_pend_valid <= 1'b0;
            end else if (start && !r_pend_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_byte  <= dataa[7:0];
                r_pend_rs    <= datab[0];
                r_pend_init  <= datab[1];
            end

            if ((r_state == C_NEXT) && w_last_init) begin
                r_init_flag <= 1'b1;
            end

            if (w_launch_pt && w_req_valid) begin
                r_init_auto <= 1'b0;
                if (w_req_init) begin
                    r_state    <= C_POWERUP;
                    r_cnt      <= C_CNT_W'(POWERUP_WAIT_CYC - 1);
                    r_init_run <= 1'b1;
                end else begin
                    r_state    <= C_SETUP;
                    r_rs       <= w_req_rs;
                    r_byte     <= w_req_byte;
                    r_init_run <= 1'b0;
                end
            end else begin
                case (r_state)
                    C_IDLE: r_state <= C_IDLE;
                    C_POWERUP: begin
                        if (r_cnt == '0) begin
                            r_state    <= C_SETUP;
                            r_rs       <= 1'b0;
                            r_byte     <= init_cmd(2'd0);
                            r_init_idx <= 2'd0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    C_SETUP: begin
                        r_state <= C_PULSE;
                        r_cnt   <= C_CNT_W'(EN_PULSE_CYC - 1);
                    end
                    C_PULSE: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (w_wait_cyc == C_CNT_W'(1)) begin
                            r_state <= C_NEXT;
                        end else begin
                            // NEXT supplies the final wait cycle
                            r_state <= C_WAIT;
                            r_cnt   <= w_wait_cyc - C_CNT_W'(2);
                        end
                    end
                    C_WAIT: begin
                        if (r_cnt == '0) begin
                            r_state <= C_NEXT;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    C_NEXT: begin
                        if (r_init_run && !w_last_init) begin
                            r_state    <= C_SETUP;
                            r_init_idx <= r_init_idx + 2'd1;
                            r_byte     <= init_cmd(r_init_idx + 2'd1);
                        end else if (w_last_init && r_init_auto) begin
                            r_state     <= C_IDLE;
                            r_init_run  <= 1'b0;
                            r_init_auto <= 1'b0;
                        end else begin
                            r_state    <= C_DONE;
                            r_init_run <= 1'b0;
                            r_result   <= {r_init_flag | r_init_run, 22'd0, r_rs, r_byte};
                        end
                    end
                    C_DONE:  r_state <= C_IDLE;
                    default: r_state <= C_IDLE;
                endcase
            end
        end
    end

    assign result     = r_result;
    assign done       = (r_state == C_DONE);
    assign lcd_enable = (r_state == C_PULSE);
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = r_byte;

endmodule
`default_nettype wire

// File: tb/tb_lcd_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_controller
// Purpose  : Self-checking bench for lcd_controller with a schedule-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_controller;

    localparam int EN = 2, CMD = 4, CLR = 8, PWR = 10;

    logic        clk = 1'b0, reset = 1'b1, clk_en = 1'b0, start = 1'b0;
    logic [31:0] dataa = 32'h0, datab = 32'h0;
    logic [31:0] result0, result1;
    logic        done0, done1, en0, en1, rs0, rs1, rw0, rw1;
    logic [7:0]  data0, data1;

    always #5 clk = ~clk;

    lcd_controller #(.EN_PULSE_CYC(EN), .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR),
                     .POWERUP_WAIT_CYC(PWR), .INIT_ON_RESET(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
        .result(result0), .done(done0), .lcd_enable(en0), .lcd_rs(rs0), .lcd_rw(rw0), .lcd_data(data0));

    lcd_controller #(.EN_PULSE_CYC(EN), .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR),
                     .POWERUP_WAIT_CYC(PWR), .INIT_ON_RESET(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
        .result(result1), .done(done1), .lcd_enable(en1), .lcd_rs(rs1), .lcd_rw(rw1), .lcd_data(data1));

    int checks = 0, failures = 0;
    int q = 0;
    bit sel = 1'b0;

    // Model: expected events keyed by clk_en-qualified cycle index
    bit          m_done [int];
    bit          m_en   [int];
    logic [8:0]  m_setup[int];
    logic [31:0] m_res  [int];
    int          m_D;
    bit          m_flag, m_pend_v;
    logic [31:0] m_pa, m_pb;
    logic [8:0]  cur_sig;
    logic [31:0] cur_res;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0F;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic sched_cmd(input int s, input bit rs, input logic [7:0] b, output int nxt);
        int w;
        m_setup[s] = {rs, b};
        for (int i = 1; i <= EN; i++) m_en[s + i] = 1'b1;
        w = (!rs && (b == 8'h01 || b == 8'h02)) ? CLR : CMD;
        nxt = s + 1 + EN + w;
    endtask

    task automatic launch(input int t, input logic [31:0] a, input logic [31:0] b, input bit auto_init);
        int s, nxt;
        if (b[1]) begin
            s = t + 1 + PWR;
            for (int i = 0; i < 4; i++) begin
                sched_cmd(s, 1'b0, init_byte(i), nxt);
                s = nxt;
            end
            m_flag = 1'b1;
            if (auto_init) m_D = s - 1;
            else begin
                m_D = s; m_done[s] = 1'b1; m_res[s] = {1'b1, 22'd0, 1'b0, 8'h06};
            end
        end else begin
            sched_cmd(t + 1, b[0], a[7:0], nxt);
            m_D = nxt; m_done[nxt] = 1'b1; m_res[nxt] = {m_flag, 22'd0, b[0], a[7:0]};
        end
    endtask

    task automatic model_reset(input bit auto_init);
        m_done.delete(); m_en.delete(); m_setup.delete(); m_res.delete();
        m_flag = 1'b0; m_pend_v = 1'b0; m_D = -1; cur_sig = '0; cur_res = '0; q = 0;
        if (auto_init) launch(-1, 32'h0, 32'h2, 1'b1);
    endtask

    task automatic model_step(input bit st, input logic [31:0] a, input logic [31:0] b);
        if (q == m_D && m_pend_v) begin
            launch(q, m_pa, m_pb, 1'b0);
            m_pend_v = 1'b0;
        end else if (st) begin
            if (q >= m_D) launch(q, a, b, 1'b0);
            else if (!m_pend_v) begin
                m_pend_v = 1'b1; m_pa = a; m_pb = b;
            end
        end
    endtask

    task automatic check_outputs();
        logic [43:0] got, exp;
        logic d, e;
        if (m_setup.exists(q)) cur_sig = m_setup[q];
        if (m_done.exists(q))  cur_res = m_res[q];
        d = m_done.exists(q) ? 1'b1 : 1'b0;
        e = m_en.exists(q) ? 1'b1 : 1'b0;
        exp = {d, e, cur_sig, 1'b0, cur_res};
        got = sel ? {done1, en1, rs1, data1, rw1, result1} : {done0, en0, rs0, data0, rw0, result0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL model q=%0d dut%0d {done,en,rs,data,rw,result}: got %h expected %h",
                     q, sel, got, exp);
        end
    endtask

    // One clock: check current outputs, drive inputs for this edge, advance the model
    task automatic cyc(input bit e, input bit st, input logic [31:0] a, input logic [31:0] b);
        check_outputs();
        clk_en = e; start = st; dataa = a; datab = b;
        if (e) begin
            model_step(st, a, b);
            q++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit auto_sel);
        reset = 1'b1; clk_en = 1'b0; start = 1'b0; dataa = '0; datab = '0;
        #1;
        check_eq("reset_dut0", {done0, en0, rs0, rw0, data0, result0}, 64'd0);
        check_eq("reset_dut1", {done1, en1, rs1, rw1, data1, result1}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sel = auto_sel;
        model_reset(auto_sel);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
        bit          chk_sig;
    } vec_t;

    vec_t        vt[9];
    int          j, ndone;
    bit          r_e, r_st;
    logic [31:0] r_a, r_b;

    initial begin
        vt[0] = '{32'h55,        32'h1,        8,  32'h0000_0155, 1'b1};
        vt[1] = '{32'hFF,        32'h2,        43, 32'h8000_0006, 1'b0};
        vt[2] = '{32'h41,        32'h1,        8,  32'h8000_0141, 1'b1};
        vt[3] = '{32'h01,        32'h0,        12, 32'h8000_0001, 1'b1};
        vt[4] = '{32'h80,        32'h0,        8,  32'h8000_0080, 1'b1};
        vt[5] = '{32'h02,        32'h0,        12, 32'h8000_0002, 1'b1};
        vt[6] = '{32'h101,       32'h1,        8,  32'h8000_0101, 1'b1};
        vt[7] = '{32'hABCD_EF03, 32'hFFFF_FFF0, 8, 32'h8000_0003, 1'b1};
        vt[8] = '{32'h12,        32'h3,        43, 32'h8000_0006, 1'b0};

        @(negedge clk);
        do_reset(1'b0);
        repeat (3) cyc(1, 0, 0, 0);

        foreach (vt[i]) begin
            cyc(1, 1, vt[i].a, vt[i].b);
            if (vt[i].chk_sig) check_eq("setup_sig", {rs0, data0}, {vt[i].b[0], vt[i].a[7:0]});
            j = 1;
            while (!done0 && j < 100) begin cyc(1, 0, 0, 0); j++; end
            check_eq("latency", j, vt[i].lat);
            check_eq("result", result0, vt[i].res);
            cyc(1, 0, 0, 0);
        end

        // Back-to-back: second start pending, third ignored
        cyc(1, 1, 32'h41, 32'h1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 32'h42, 32'h1);
        cyc(1, 1, 32'h43, 32'h1);
        ndone = 0;
        for (int k = 5; k <= 20; k++) begin
            if (done0) begin
                check_eq("b2b_done_time", k, (ndone == 0) ? 8 : 16);
                check_eq("b2b_result", result0, (ndone == 0) ? 32'h8000_0141 : 32'h8000_0142);
                ndone++;
            end
            cyc(1, 0, 0, 0);
        end
        check_eq("b2b_done_count", ndone, 2);

        // clk_en freeze in the middle of the strobe; starts during freeze ignored
        cyc(1, 1, 32'h61, 32'h1);
        cyc(1, 0, 0, 0);
        check_eq("freeze_en_high", en0, 1);
        repeat (4) cyc(0, 1, 32'h77, 32'h1);
        check_eq("freeze_en_held", en0, 1);
        j = 6;
        while (!done0 && j < 100) begin cyc(1, 0, 0, 0); j++; end
        check_eq("freeze_latency", j, 12);
        check_eq("freeze_result", result0, 32'h8000_0161);
        cyc(0, 0, 0, 0);
        check_eq("done_hold_frozen", done0, 1);
        cyc(1, 0, 0, 0);
        repeat (12) cyc(1, 0, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r_e  = ($urandom_range(0, 7) != 0);
            r_st = ($urandom_range(0, 5) == 0);
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 3))
                0:       r_a[7:0] = 8'h01;
                1:       r_a[7:0] = 8'h02;
                default: ;
            endcase
            r_b[1] = ($urandom_range(0, 24) == 0);
            cyc(r_e, r_st, r_a, r_b);
        end
        repeat (60) cyc(1, 0, 0, 0);

        // Reset during the strobe with a request pending
        cyc(1, 1, 32'h41, 32'h1);
        cyc(1, 1, 32'h42, 32'h1);
        check_eq("pulse_before_reset", en0, 1);
        do_reset(1'b0);
        repeat (30) cyc(1, 0, 0, 0);

        // Automatic init with a request queued during power-up
        do_reset(1'b1);
        ndone = 0;
        for (int k = 0; k <= 60; k++) begin
            if (k == 10) check_eq("auto_first_cmd", {rs1, data1}, 9'h038);
            if (done1) begin
                check_eq("auto_done_time", k, 49);
                check_eq("auto_result", result1, 32'h8000_0141);
                ndone++;
            end
            cyc(1, (k == 5), 32'h41, 32'h1);
        end
        check_eq("auto_done_count", ndone, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 Parameter EN_PULSE_CYC, default 25, sets the lcd_enable high time in clk cycles; legal range is 1 or more.
REQ-002 Parameter CMD_WAIT_CYC, default 2500, sets the post-pulse wait for ordinary commands and data; legal range is 1 or more.
REQ-003 Parameter CLEAR_WAIT_CYC, default 82000, sets the post-pulse wait for command bytes 0x01 and 0x02 (rs=0).
REQ-004 Parameter POWERUP_WAIT_CYC, default 750000, sets the idle wait before the first init command.
REQ-005 Parameter INIT_ON_RESET, default 1; when 1, the init sequence runs automatically after reset release.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port clk_en, input, 1 bit: custom-instruction clock enable; the FSM, counters and outputs hold while it is 0.
REQ-009 Port start, input, 1 bit: one-cycle operation request, sampled only when clk_en=1.
REQ-010 Port dataa, input, 32 bits: dataa[7:0] is the byte to write; bits [31:8] are ignored.
REQ-011 Port datab, input, 32 bits: datab[0] is rs (0=command, 1=data); datab[1] is init request; bits [31:2] are ignored.
REQ-012 Port result, output, 32 bits: {init_flag, 22'b0, rs, byte} of the completed operation.
REQ-013 Port done, output, 1 bit: one-cycle completion pulse.
REQ-014 Port lcd_enable, output, 1 bit: LCD E strobe.
REQ-015 Port lcd_rs, output, 1 bit: LCD register select.
REQ-016 Port lcd_rw, output, 1 bit: tied to constant 0 (write-only).
REQ-017 Port lcd_data, output, 8 bits: LCD data bus.

Function
REQ-018 The FSM shall have the states IDLE, POWERUP, SETUP, PULSE, WAIT, NEXT and DONE.
REQ-019 Start accepted in IDLE at cycle T shall produce: SETUP at T+1 (lcd_rs and lcd_data valid, en=0); en=1 for cycles T+2..T+1+EN_PULSE_CYC; en=0 WAIT for W cycles; done=1 at T+2+EN_PULSE_CYC+W.
REQ-020 W shall equal CLEAR_WAIT_CYC when rs=0 and byte is 0x01 or 0x02, and CMD_WAIT_CYC otherwise.
REQ-021 lcd_rs and lcd_data shall stay stable from SETUP until the next SETUP.
REQ-022 datab[1]=1 shall run the init sequence and ignore dataa and datab[0].
REQ-023 The init sequence shall be POWERUP for POWERUP_WAIT_CYC cycles, then commands 0x38, 0x0F, 0x01 and 0x06, each run as in REQ-019 with no gap between commands.
REQ-024 Completion of the init sequence shall set init_flag=1, and init_flag shall stay 1 until reset.
REQ-025 Completion of an instructed init shall pulse done with result=0x80000006.
REQ-026 An automatic init (INIT_ON_RESET=1) shall not pulse done.
REQ-027 A start arriving when not in IDLE shall be latched in a one-deep pending register (dataa[7:0], datab[1:0]).
REQ-028 A pending request shall enter SETUP (or POWERUP for init) in the cycle after the current operation's DONE or auto-init end.
REQ-029 A start arriving while the pending register is full shall be ignored.
REQ-030 A start in the same cycle as DONE shall be latched as pending.
REQ-031 done shall be high for exactly one clk_en-qualified cycle; result shall hold its value until the next done.
REQ-032 When clk_en=0, all counters shall freeze, outputs shall hold, and start shall be ignored.
REQ-033 All wait counters shall be at least 20 bits wide so the default parameters do not overflow.

Reset
REQ-034 While reset=1: result=0, done=0, lcd_enable=0, lcd_rs=0, lcd_data=0x00, init_flag=0, pending empty.
REQ-035 On reset release, the FSM shall go to POWERUP if INIT_ON_RESET=1, otherwise to IDLE.
REQ-036 Reset mid-operation shall drop lcd_enable immediately and discard the in-flight and pending requests without a done pulse.

Verification
(All scenarios use EN_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8, POWERUP_WAIT_CYC=10.)
REQ-037 With INIT_ON_RESET=0, start at T with datab=0x2 -> lcd_data sequence 0x38, 0x0F, 0x01, 0x06; done at T+43; result=0x80000006.
REQ-038 After init, start at T with dataa=0x41, datab=0x1 -> lcd_rs=1 and lcd_data=0x41 at T+1; en=1 at T+2 and T+3; done at T+8; result=0x80000141.
REQ-039 Start with rs=0, byte 0x01 at T -> done at T+12; byte 0x80 at T -> done at T+8.
REQ-040 Start at T (0x41, data) and start at T+3 (0x42, data), third start at T+4 ignored -> done at T+8 (0x41) and T+16 (0x42) only.
REQ-041 With INIT_ON_RESET=1, start at cycle 5 after reset release -> auto-init completes without done; pending request runs next and pulses done with bit31=1.
REQ-042 Assert reset during PULSE -> lcd_enable=0 in the same cycle; no done pulse; all outputs at their REQ-034 values.
